// File: rtl/logic_unit_pkg.sv
// Shared types for seq_logic_unit: operation codes and FSM states.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_BIC   = 3'd6,
        OP_PASSA = 3'd7
    } logic_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator shared across all result slices.
import logic_unit_pkg::*;

module logic_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic_op_t        op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_BIC:   y = a & ~b;
            OP_PASSA: y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// Slice-serial bitwise logic unit with valid/ready handshakes on both sides.
// Optional parity output enabled by defining LOGIC_UNIT_PARITY_EN.
import logic_unit_pkg::*;

module seq_logic_unit #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] slice_cnt;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic_op_t        op_q;
    logic             zero_acc, zero_q, neg_q;
    logic             accept, last_slice, slice_zero;
    logic [SLICE-1:0] a_sl, b_sl, y_sl;

`ifdef LOGIC_UNIT_PARITY_EN
    logic par_acc, parity_q;
`endif

    assign a_sl       = a_q[slice_cnt*SLICE +: SLICE];
    assign b_sl       = b_q[slice_cnt*SLICE +: SLICE];
    assign last_slice = (slice_cnt == LAST);
    assign slice_zero = ~|y_sl;
    assign accept     = in_valid && in_ready;

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_q),
        .y  (y_sl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // in_ready in DONE follows out_ready combinationally so a result can be
    // retired and the next request accepted on the same edge.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            slice_cnt <= '0;
            result_q  <= '0;
            zero_acc  <= 1'b1;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            par_acc   <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q       <= A;
            b_q       <= B;
            op_q      <= logic_op_t'(op);
            slice_cnt <= '0;
            zero_acc  <= 1'b1;
`ifdef LOGIC_UNIT_PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else if (state_q == BUSY) begin
            result_q[slice_cnt*SLICE +: SLICE] <= y_sl;
            zero_acc <= zero_acc & slice_zero;
`ifdef LOGIC_UNIT_PARITY_EN
            par_acc  <= par_acc ^ (^y_sl);
`endif
            // Flags only update on the final slice so they never show a
            // partially computed value ahead of out_valid.
            if (last_slice) begin
                zero_q   <= zero_acc & slice_zero;
                neg_q    <= y_sl[SLICE-1];
`ifdef LOGIC_UNIT_PARITY_EN
                parity_q <= par_acc ^ (^y_sl);
`endif
            end else begin
                slice_cnt <= slice_cnt + 1'b1;
            end
        end
    end

    assign result   = result_q;
    assign negative = neg_q;
    assign zero     = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
    assign parity   = parity_q;
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed self-checking bench for seq_logic_unit (64/16 and 8/8 configurations).
module tb_seq_logic_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, negative, zero;
    logic [2:0]  op = 3'd0;
    logic [63:0] A = '0, B = '0, result;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic        in_ready8, out_valid8, negative8, zero8;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  A8 = '0, B8 = '0, result8;

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity, parity8;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_logic_unit #(.WIDTH(64), .SLICE(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero)
`ifdef LOGIC_UNIT_PARITY_EN
        , .parity(parity)
`endif
    );

    seq_logic_unit #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .A(A8), .B(B8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .negative(negative8), .zero(zero8)
`ifdef LOGIC_UNIT_PARITY_EN
        , .parity(parity8)
`endif
    );

    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (result !== 64'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b want 1", zero); end
        vectors++; if (negative !== 1'b0) begin miscompares++; $display("FAIL reset_negative got %b want 0", negative); end
`ifdef LOGIC_UNIT_PARITY_EN
        vectors++; if (parity !== 1'b0) begin miscompares++; $display("FAIL reset_parity got %b want 0", parity); end
`endif
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL idle_handshake got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        int cyc;
        out_ready = 1'b1;
        issue(o, a, b);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early_valid got %b want 0", name, out_valid); end
        wait_valid(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL %s_latency got %0d want 4", name, cyc); end
        vectors++; if (result !== exp) begin miscompares++; $display("FAIL %s_result got %h want %h", name, result, exp); end
        vectors++; if (negative !== exp[63]) begin miscompares++; $display("FAIL %s_negative got %b want %b", name, negative, exp[63]); end
        vectors++; if (zero !== (exp == 64'h0)) begin miscompares++; $display("FAIL %s_zero got %b want %b", name, zero, (exp == 64'h0)); end
`ifdef LOGIC_UNIT_PARITY_EN
        vectors++; if (parity !== ^exp) begin miscompares++; $display("FAIL %s_parity got %b want %b", name, parity, ^exp); end
`endif
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL %s_retire got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_ops;
        run_op("and",  3'd0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000);
        run_op("xor",  3'd2, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'h0);
        run_op("nor",  3'd4, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("nand", 3'd3, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_FFFF_FFFF);
        run_op("xnor", 3'd5, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF00F_F00F_F00F_F00F);
        run_op("bic",  3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
        run_op("or",   3'd1, 64'h1234_5678_0000_0000, 64'h0000_0000_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    endtask

    task automatic test_back_to_back;
        int cyc;
        out_ready = 1'b0;
        issue(3'd1, 64'h1234_5678_0000_0000, 64'h0000_0000_9ABC_DEF0);
        wait_valid(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL bp_latency got %0d want 4", cyc); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'h1234_5678_9ABC_DEF0 || zero !== 1'b0 || negative !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b res=%h z=%b n=%b want vld=1 rdy=0 res=123456789abcdef0 z=0 n=0",
                         i, out_valid, in_ready, result, zero, negative);
            end
        end
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd7; A = 64'h8000_0000_0000_0000; B = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_accept got vld=%b rdy=%b want vld=0 rdy=0", out_valid, in_ready);
        end
        // Operand/opcode changes after acceptance must not affect the result.
        op = 3'd2; A = '0; B = 64'h5555_5555_5555_5555;
        wait_valid(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL b2b_latency got %0d want 4", cyc); end
        vectors++; if (result !== 64'h8000_0000_0000_0000 || negative !== 1'b1 || zero !== 1'b0) begin
            miscompares++; $display("FAIL b2b_result got res=%h n=%b z=%b want res=8000000000000000 n=1 z=0", result, negative, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy;
        issue(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0 || zero !== 1'b1) begin
            miscompares++; $display("FAIL midreset got rdy=%b vld=%b res=%h z=%b want rdy=1 vld=0 res=0 z=1", in_ready, out_valid, result, zero);
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midreset_discard got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_width8;
        int cyc;
        @(negedge clk);
        in_valid8 = 1'b1; op8 = 3'd6; A8 = 8'hF0; B8 = 8'h30;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++; if (cyc != 1) begin miscompares++; $display("FAIL w8_latency got %0d want 1", cyc); end
        vectors++; if (result8 !== 8'hC0 || negative8 !== 1'b1 || zero8 !== 1'b0) begin
            miscompares++; $display("FAIL w8_bic got res=%h n=%b z=%b want res=c0 n=1 z=0", result8, negative8, zero8);
        end
    endtask

    initial begin
        test_reset;
        test_ops;
        test_back_to_back;
        test_reset_mid_busy;
        test_width8;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
